// File: rtl/page_writer.sv
// Overlay page loader: RGB888 pixel stream -> packed RGB565 words
// written sequentially into SDRAM through the App_wr_* port.
module page_writer #(
  parameter int PAGE_WIDTH  = 300,
  parameter int PAGE_HEIGHT = 500,
  parameter int ADDR_WIDTH  = 21,
  parameter int DATA_WIDTH  = 32,
  parameter int DM_WIDTH    = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [23:0]           pix_data,
  input  logic                  sdr_init_done,
  input  logic                  sdr_init_ref_vld,
  input  logic                  sdr_busy,
  output logic                  app_wr_en,
  output logic [ADDR_WIDTH-1:0] app_wr_addr,
  output logic [DM_WIDTH-1:0]   app_wr_dm,
  output logic [DATA_WIDTH-1:0] app_wr_din,
  output logic                  busy,
  output logic                  done
);

  localparam int NPIX = PAGE_WIDTH * PAGE_HEIGHT;
  localparam int CW   = $clog2(NPIX + 1);

  localparam logic [CW-1:0] LAST = CW'(NPIX - 1);
  localparam logic [CW-1:0] ALL  = CW'(NPIX);

  localparam logic [DM_WIDTH-1:0] DM_HALF = DM_WIDTH'(4'b1100);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } state_t;

  state_t state, nxt;

  logic [CW-1:0] cnt;
  logic          gate;
  logic          take;
  logic          word_end;
  logic [15:0]   rgb;

  assign gate = sdr_init_done & ~sdr_init_ref_vld & ~sdr_busy;
  assign rgb  = {pix_data[23:19], pix_data[15:10], pix_data[7:3]};
  assign take = pix_valid & pix_ready;

  // A word closes on an odd pixel or on a lone trailing pixel.
  assign word_end = cnt[0] | (cnt == LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt       = state;
    pix_ready = 1'b0;
    app_wr_en = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) nxt = FILL;
      end
      FILL: begin
        pix_ready = 1'b1;
        if (pix_valid && word_end) nxt = WRITE;
      end
      WRITE: begin
        app_wr_en = gate;
        if (gate) nxt = (cnt == ALL) ? DONE : FILL;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt         <= '0;
      app_wr_addr <= '0;
      app_wr_din  <= '0;
      app_wr_dm   <= '0;
      busy        <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        app_wr_addr <= base_addr;
        cnt         <= '0;
        busy        <= 1'b1;
      end
      if (take) begin
        cnt <= cnt + 1'b1;
        if (!cnt[0]) begin
          app_wr_din[15:0]  <= rgb;
          app_wr_din[31:16] <= '0;
          app_wr_dm <= (cnt == LAST) ? DM_HALF : '0;
        end else begin
          app_wr_din[31:16] <= rgb;
        end
      end
      // The address stays on the last word once the page is complete.
      if (app_wr_en && cnt != ALL) begin
        app_wr_addr <= app_wr_addr + 1'b1;
      end
      if (state == DONE) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_page_writer.sv
// Bench for page_writer: transaction-level model plus
// directed pages with hand-computed expected words.
module tb_page_writer;

  localparam int PW     = 5;
  localparam int PH     = 3;
  localparam int NPIX   = PW * PH;
  localparam int NWORDS = (NPIX + 1) / 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [20:0] base_addr = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [23:0] pix_data = '0;
  logic        sdr_init_done = 1'b0;
  logic        sdr_init_ref_vld = 1'b0;
  logic        sdr_busy = 1'b0;
  logic        app_wr_en;
  logic [20:0] app_wr_addr;
  logic [3:0]  app_wr_dm;
  logic [31:0] app_wr_din;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  page_writer #(
    .PAGE_WIDTH (PW),
    .PAGE_HEIGHT(PH)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .start           (start),
    .base_addr       (base_addr),
    .pix_valid       (pix_valid),
    .pix_ready       (pix_ready),
    .pix_data        (pix_data),
    .sdr_init_done   (sdr_init_done),
    .sdr_init_ref_vld(sdr_init_ref_vld),
    .sdr_busy        (sdr_busy),
    .app_wr_en       (app_wr_en),
    .app_wr_addr     (app_wr_addr),
    .app_wr_dm       (app_wr_dm),
    .app_wr_din      (app_wr_din),
    .busy            (busy),
    .done            (done)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [23:0] pix   [NPIX];
  logic [31:0] e_din [NWORDS];
  logic [3:0]  e_dm  [NWORDS];

  logic [20:0] cap_addr [1024];
  logic [31:0] cap_din  [1024];
  logic [3:0]  cap_dm   [1024];
  int n_wr = 0;
  int w0 = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to565(input logic [23:0] p);
    int r, g, b;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    return 16'((r / 8) * 2048 + (g / 4) * 32 + (b / 8));
  endfunction

  task automatic build_words();
    logic [15:0] lo, hi;
    for (int w = 0; w < NWORDS; w++) begin
      lo = to565(pix[2*w]);
      if (2*w + 1 < NPIX) begin
        hi = to565(pix[2*w+1]);
        e_dm[w] = 4'h0;
      end else begin
        hi = 16'h0;
        e_dm[w] = 4'hC;
      end
      e_din[w] = {hi, lo};
    end
  endtask

  // Transaction-level model: counts pixels taken and words written.
  initial begin
    logic        m_active, m_fin, m_pend;
    int          m_npix, m_nwr;
    logic [20:0] m_base, e_addr;
    logic        g, e_ready, e_en;
    m_active = 0; m_fin = 0; m_pend = 0;
    m_npix = 0; m_nwr = 0; m_base = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        chk("rst_ready", 32'(pix_ready), 0);
        chk("rst_en", 32'(app_wr_en), 0);
        chk("rst_addr", 32'(app_wr_addr), 0);
        chk("rst_din", app_wr_din, 0);
        chk("rst_dm", 32'(app_wr_dm), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        m_active = 0; m_fin = 0; m_pend = 0;
      end else begin
        g = sdr_init_done && !sdr_init_ref_vld && !sdr_busy;
        e_ready = m_active && !m_pend;
        e_en = m_pend && g;
        chk("ready", 32'(pix_ready), 32'(e_ready));
        chk("wr_en", 32'(app_wr_en), 32'(e_en));
        chk("done", 32'(done), 32'(m_fin));
        chk("busy", 32'(busy), 32'(m_active || m_fin));
        if (m_pend) begin
          e_addr = m_base + 21'(m_nwr);
          chk("addr", 32'(app_wr_addr), 32'(e_addr));
          chk("din", app_wr_din, e_din[m_nwr]);
          chk("dm", 32'(app_wr_dm), 32'(e_dm[m_nwr]));
        end
        if (app_wr_en && n_wr < 1024) begin
          cap_addr[n_wr] = app_wr_addr;
          cap_din[n_wr] = app_wr_din;
          cap_dm[n_wr] = app_wr_dm;
          n_wr++;
        end
        if (m_fin) begin
          m_fin = 0;
        end else if (!m_active) begin
          if (start) begin
            m_active = 1; m_base = base_addr;
            m_npix = 0; m_nwr = 0; m_pend = 0;
          end
        end else begin
          if (e_ready && pix_valid) begin
            m_npix++;
            if (m_npix % 2 == 0 || m_npix == NPIX) m_pend = 1;
          end
          if (e_en) begin
            m_nwr++;
            m_pend = 0;
            if (m_nwr == NWORDS) begin
              m_active = 0;
              m_fin = 1;
            end
          end
        end
      end
    end
  end

  task automatic set_gate(input int gmode, input logic hold);
    sdr_init_done = 1'b1;
    sdr_init_ref_vld = 1'b0;
    sdr_busy = 1'b0;
    if (hold && gmode == 1) sdr_busy = 1'b1;
    if (hold && gmode == 2) sdr_init_ref_vld = 1'b1;
    if (hold && gmode == 3) sdr_init_done = 1'b0;
    if (gmode == 4) begin
      sdr_init_ref_vld = ($urandom_range(0, 4) == 0);
      sdr_busy = ($urandom_range(0, 2) == 0);
    end
  endtask

  task automatic run_page(input logic [20:0] base, input int vmode,
                          input int gmode, input int hold,
                          input int abort_at, input int midstart);
    int   idx, en_hold;
    logic hs, dn, fin;
    idx = 0; en_hold = 0; fin = 0;
    w0 = n_wr;
    build_words();
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = base;
    for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
      set_gate(gmode, cyc < hold);
      pix_valid = (vmode == 0) || ($urandom_range(0, 2) != 0);
      pix_data = (idx < NPIX) ? pix[idx] : 24'hABCDEF;
      @(negedge clk);
      hs = pix_valid && pix_ready;
      dn = done;
      if (cyc < hold && app_wr_en) en_hold++;
      @(posedge clk); #1;
      start = 1'b0;
      if (hs) idx++;
      if (dn) fin = 1'b1;
      if (cyc == midstart) begin
        start = 1'b1;
        base_addr = 21'h1ABCD;
      end
      if (cyc == abort_at) begin
        rstn = 1'b0;
        #1;
        chk("abort_ready", 32'(pix_ready), 0);
        chk("abort_en", 32'(app_wr_en), 0);
        chk("abort_addr", 32'(app_wr_addr), 0);
        chk("abort_din", app_wr_din, 0);
        chk("abort_busy", 32'(busy), 0);
        @(negedge clk);
        @(posedge clk); #1;
        rstn = 1'b1;
        pix_valid = 1'b0;
        return;
      end
    end
    chk("page_done", 32'(fin), 1);
    chk("page_writes", 32'(n_wr - w0), NWORDS);
    if (hold > 0) chk("gate_hold_en", 32'(en_hold), 0);
    pix_valid = 1'b0;
    set_gate(0, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("reset_addr", 32'(app_wr_addr), 0);
    chk("reset_busy", 32'(busy), 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    set_gate(0, 1'b0);

    pix[0] = 24'hFF0000;
    pix[1] = 24'h00FF00;
    pix[2] = 24'h0000FF;
    pix[3] = 24'hFFFFFF;
    for (int i = 4; i < NPIX; i++) pix[i] = 24'(i * 24'h0F1E2D);
    run_page(21'h100, 0, 0, 0, -1, -1);
    chk("basic_din0", cap_din[w0], 32'h07E0F800);
    chk("basic_din1", cap_din[w0+1], 32'hFFFF001F);
    chk("basic_addr0", 32'(cap_addr[w0]), 32'h100);
    chk("basic_addr7", 32'(cap_addr[w0+7]), 32'h107);
    chk("basic_dm0", 32'(cap_dm[w0]), 0);
    chk("basic_dm7", 32'(cap_dm[w0+7]), 32'hC);

    for (int i = 0; i < NPIX; i++) pix[i] = 24'h0000FF;
    run_page(21'h40, 0, 0, 0, -1, -1);
    chk("odd_din0", cap_din[w0], 32'h001F001F);
    chk("odd_din_last", cap_din[w0+7], 32'h0000001F);
    chk("odd_dm_last", 32'(cap_dm[w0+7]), 32'hC);

    for (int g = 1; g <= 3; g++) begin
      for (int i = 0; i < NPIX; i++) pix[i] = 24'($urandom);
      run_page(21'h200, 0, g, 14, -1, -1);
      chk("gate_addr0", 32'(cap_addr[w0]), 32'h200);
    end

    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < NPIX; i++) pix[i] = 24'($urandom);
      run_page(21'(32'h1000 * (p + 1)), 1, 4, 0, -1, -1);
    end

    for (int i = 0; i < NPIX; i++) pix[i] = 24'($urandom);
    run_page(21'h300, 1, 4, 0, -1, 5);
    chk("midstart_addr7", 32'(cap_addr[w0+7]), 32'h307);

    run_page(21'h400, 0, 0, 0, 6, -1);
    run_page(21'h2000, 0, 0, 0, -1, -1);
    chk("restart_addr0", 32'(cap_addr[w0]), 32'h2000);

    run_page(21'h1FFFFF, 0, 0, 0, -1, -1);
    chk("wrap_addr0", 32'(cap_addr[w0]), 32'h1FFFFF);
    chk("wrap_addr1", 32'(cap_addr[w0+1]), 32'h0);
    chk("wrap_addr7", 32'(cap_addr[w0+7]), 32'h6);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
